// File: rtl/fetch_prefetch_queue.sv
// fetch_prefetch_queue: prefetching instruction-fetch front end feeding IF/ID over a req/gnt/rvalid memory port.
// Optional FETCH_PERF_EN adds saturating stall and drop counters.
module fetch_prefetch_queue #(
  parameter int DEPTH = 4,
  parameter int ADDR_W = 8,
  parameter int DATA_W = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     hold,
  input  logic                     redirect,
  input  logic [ADDR_W-1:0]        redirect_pc,
  output logic                     imem_req,
  output logic [ADDR_W-1:0]        imem_addr,
  input  logic                     imem_gnt,
  input  logic                     imem_rvalid,
  input  logic [DATA_W-1:0]        imem_rdata,
  output logic                     out_valid,
  output logic [DATA_W-1:0]        out_instr,
  output logic [ADDR_W-1:0]        out_pc_p1,
  output logic [$clog2(DEPTH):0]   fifo_count
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0]              perf_stall_cycles,
  output logic [15:0]              perf_drops
`endif
);
  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0] FULL = (PW+1)'(DEPTH);
  localparam logic [1:0] FETCH = 2'd0, WAIT = 2'd1, DROP = 2'd2;
  logic [1:0] state;
  logic [ADDR_W-1:0] fetch_pc, req_pc;
  logic [PW-1:0] rd_ptr, wr_ptr;
  logic [PW:0] count;
  logic [DATA_W-1:0] instr_q [DEPTH];
  logic [ADDR_W-1:0] pc_q [DEPTH];
  logic req, push, pop;
  always_comb begin
    req = state == FETCH && count < FULL && !redirect;
    push = state == WAIT && imem_rvalid && !redirect;
    pop = count != '0 && !hold && !redirect;
    imem_req = !reset && req;
    imem_addr = reset ? '0 : fetch_pc;
    out_valid = !reset && count != '0;
    out_instr = reset ? '0 : instr_q[rd_ptr];
    out_pc_p1 = reset ? '0 : pc_q[rd_ptr];
    fifo_count = reset ? '0 : count;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= FETCH;
      fetch_pc <= RESET_PC;
      req_pc <= '0;
      count <= '0;
      rd_ptr <= '0;
      wr_ptr <= '0;
    end else if (redirect) begin
      count <= '0;
      rd_ptr <= '0;
      wr_ptr <= '0;
      fetch_pc <= redirect_pc;
      // an outstanding response that has not yet arrived must be swallowed in DROP
      state <= (state == FETCH || imem_rvalid) ? FETCH : DROP;
    end else begin
      if (req && imem_gnt) begin
        req_pc <= fetch_pc;
        fetch_pc <= fetch_pc + ADDR_W'(1);
        state <= WAIT;
      end else if (state != FETCH && imem_rvalid) state <= FETCH;
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop) rd_ptr <= rd_ptr + PW'(1);
      count <= count + (PW+1)'(push) - (PW+1)'(pop);
    end
  end
  always_ff @(posedge clk) begin
    if (push && !reset) begin
      instr_q[wr_ptr] <= imem_rdata;
      pc_q[wr_ptr] <= req_pc + ADDR_W'(1);
    end
  end
`ifdef FETCH_PERF_EN
  logic [31:0] stall_q;
  logic [15:0] drops_q;
  always_ff @(posedge clk) begin
    if (reset) begin
      stall_q <= '0;
      drops_q <= '0;
    end else begin
      if (state == FETCH && count == FULL && stall_q != '1) stall_q <= stall_q + 32'd1;
      if (imem_rvalid && (state == DROP || (state == WAIT && redirect)) && drops_q != '1) drops_q <= drops_q + 16'd1;
    end
  end
  always_comb begin
    perf_stall_cycles = reset ? '0 : stall_q;
    perf_drops = reset ? '0 : drops_q;
  end
`endif
endmodule

// File: tb/tb_fetch_prefetch_queue.sv
// tb_fetch_prefetch_queue: scoreboard bench with a variable-latency memory model and directed fetch scenarios.
module tb_fetch_prefetch_queue;
  logic clk = 0;
  logic reset = 1, hold = 0, redirect = 0;
  logic [7:0] redirect_pc = '0;
  logic imem_req, imem_gnt, imem_rvalid;
  logic [7:0] imem_addr;
  logic [31:0] imem_rdata;
  logic out_valid;
  logic [31:0] out_instr;
  logic [7:0] out_pc_p1;
  logic [2:0] fifo_count;
`ifdef FETCH_PERF_EN
  logic [31:0] perf_stall_cycles;
  logic [15:0] perf_drops;
`endif
  int checks = 0, failures = 0;
  int budget = 0, lat = 1;
  logic [39:0] exp_q[$];

  fetch_prefetch_queue dut (
    .clk(clk), .reset(reset), .hold(hold), .redirect(redirect), .redirect_pc(redirect_pc),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .out_valid(out_valid), .out_instr(out_instr), .out_pc_p1(out_pc_p1), .fifo_count(fifo_count)
`ifdef FETCH_PERF_EN
    , .perf_stall_cycles(perf_stall_cycles), .perf_drops(perf_drops)
`endif
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] f(input logic [7:0] a);
    return {16'hC0DE, a, ~a};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%h want=%h @%0t", name, act, exp, $time);
    end
  endtask

  task automatic expect_pc(input logic [7:0] a);
    exp_q.push_back({f(a), a + 8'd1});
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic wait_count(input logic [2:0] n);
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (fifo_count == n) break;
    end
    chk("fill_count", 32'(fifo_count), 32'(n));
  endtask

  task automatic wait_gnt;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (imem_gnt) break;
    end
    chk("gnt_seen", 32'(imem_gnt), 32'd1);
  endtask

  task automatic drain;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (exp_q.size() == 0) break;
    end
    chk("drain", exp_q.size(), 0);
  endtask

  // Memory: grants while budget remains, one outstanding request, response after lat cycles.
  initial begin
    bit pend = 0;
    int wc = 0;
    logic [7:0] paddr = '0;
    imem_gnt = 0;
    imem_rvalid = 0;
    imem_rdata = '0;
    forever begin
      @(posedge clk);
      #2;
      imem_gnt = 0;
      imem_rvalid = 0;
      if (reset) pend = 0;
      else if (pend) begin
        wc--;
        if (wc == 0) begin
          imem_rvalid = 1;
          imem_rdata = f(paddr);
          pend = 0;
        end
      end else if (imem_req && budget > 0) begin
        imem_gnt = 1;
        pend = 1;
        paddr = imem_addr;
        wc = lat;
        budget--;
      end
    end
  end

  // Monitor: every head consumed by IF/ID must match the scoreboard front.
  initial begin
    logic [39:0] e;
    forever begin
      @(negedge clk);
      if (!reset && out_valid && !hold && !redirect) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL pop_unexpected got instr=%h pc_p1=%h want=none", out_instr, out_pc_p1);
        end else begin
          e = exp_q.pop_front();
          chk("pop_instr", out_instr, e[39:8]);
          chk("pop_pc_p1", 32'(out_pc_p1), 32'(e[7:0]));
        end
      end
    end
  end

  initial begin
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_req", 32'(imem_req), 0);
    chk("rst_valid", 32'(out_valid), 0);
    chk("rst_count", 32'(fifo_count), 0);
    chk("rst_addr", 32'(imem_addr), 0);
    // 1-cycle memory: latency and in-order delivery
    tick;
    reset = 0; budget = 3; lat = 1;
    for (int a = 0; a < 3; a++) expect_pc(8'(a));
    @(negedge clk);
    chk("c0_req", 32'(imem_req), 1);
    chk("c0_addr", 32'(imem_addr), 0);
    @(negedge clk);
    chk("c1_valid", 32'(out_valid), 0);
    chk("c1_req", 32'(imem_req), 0);
    @(negedge clk);
    chk("c2_valid", 32'(out_valid), 1);
    chk("c2_instr", out_instr, f(8'd0));
    chk("c2_pc_p1", 32'(out_pc_p1), 1);
    chk("c2_addr", 32'(imem_addr), 1);
    drain;
    // hold: FIFO fills to DEPTH, request stays low
    tick;
    hold = 1; budget = 6; lat = 1;
    for (int a = 3; a < 9; a++) expect_pc(8'(a));
    repeat (20) @(negedge clk);
    chk("hold_count", 32'(fifo_count), 4);
    chk("hold_req", 32'(imem_req), 0);
    chk("hold_head", out_instr, f(8'd3));
    chk("hold_pc_p1", 32'(out_pc_p1), 4);
    tick;
    hold = 0;
    @(negedge clk);
    chk("unhold_req0", 32'(imem_req), 0);
    chk("unhold_addr", 32'(imem_addr), 7);
    @(negedge clk);
    chk("unhold_req1", 32'(imem_req), 1);
    drain;
    // redirect while WAIT, response three cycles later
    tick;
    hold = 1; budget = 2; lat = 1;
    wait_count(3'd2);
    tick;
    budget = 1; lat = 4;
    wait_gnt;
    tick;
    redirect = 1; redirect_pc = 8'h40; hold = 0; budget = 3; lat = 1;
    for (int a = 'h40; a < 'h43; a++) expect_pc(8'(a));
    tick;
    redirect = 0;
    @(negedge clk);
    chk("rw_count", 32'(fifo_count), 0);
    chk("rw_valid", 32'(out_valid), 0);
    chk("rw_drop_req", 32'(imem_req), 0);
    @(negedge clk);
    @(negedge clk);
    chk("rw_rvalid", 32'(imem_rvalid), 1);
    chk("rw_rvalid_req", 32'(imem_req), 0);
    @(negedge clk);
    chk("rw_req", 32'(imem_req), 1);
    chk("rw_addr", 32'(imem_addr), 32'h40);
    chk("rw_dropped", 32'(fifo_count), 0);
    drain;
    // redirect coincident with rvalid: no DROP, data discarded
    tick;
    budget = 1; lat = 2;
    wait_gnt;
    tick;
    tick;
    redirect = 1; redirect_pc = 8'h80;
    @(negedge clk);
    chk("rr_rvalid", 32'(imem_rvalid), 1);
    tick;
    redirect = 0; budget = 2; lat = 1;
    expect_pc(8'h80);
    expect_pc(8'h81);
    @(negedge clk);
    chk("rr_req", 32'(imem_req), 1);
    chk("rr_addr", 32'(imem_addr), 32'h80);
    chk("rr_count", 32'(fifo_count), 0);
    drain;
    // wrap-around; redirect also masks a grant offered in the same cycle
    tick;
    redirect = 1; redirect_pc = 8'hFE; budget = 3;
    expect_pc(8'hFE);
    expect_pc(8'hFF);
    expect_pc(8'h00);
    tick;
    redirect = 0;
    drain;
    @(negedge clk);
    chk("wrap_next_addr", 32'(imem_addr), 1);
    // reset while WAIT with count=2
    tick;
    hold = 1; budget = 2; lat = 1;
    wait_count(3'd2);
    tick;
    budget = 1; lat = 5;
    wait_gnt;
    tick;
    reset = 1;
    @(negedge clk);
    chk("mr_req", 32'(imem_req), 0);
    chk("mr_addr", 32'(imem_addr), 0);
    chk("mr_valid", 32'(out_valid), 0);
    chk("mr_instr", out_instr, 0);
    chk("mr_pc_p1", 32'(out_pc_p1), 0);
    chk("mr_count", 32'(fifo_count), 0);
    tick;
    reset = 0; hold = 0; budget = 1; lat = 1;
    expect_pc(8'h00);
    @(negedge clk);
    chk("pr_req", 32'(imem_req), 1);
    chk("pr_addr", 32'(imem_addr), 0);
    chk("pr_count", 32'(fifo_count), 0);
`ifdef FETCH_PERF_EN
    chk("pr_stall", perf_stall_cycles, 0);
    chk("pr_drops", 32'(perf_drops), 0);
`endif
    drain;
    repeat (10) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/fetch_prefetch_queue.md
Name: fetch_prefetch_queue

Overview:
Instruction-fetch front end that sits directly upstream of the IF/ID pipeline register. It replaces the combinational PC-to-instruction-memory path.
- Issues word-address requests to a variable-latency instruction memory over a req/gnt/rvalid handshake.
- Buffers returned instructions, each paired with its PC+1, in a small FIFO.
- Presents the FIFO head to IF/ID, honouring the pipeline hold (stall) and redirect (branch/jump flush) from the decode stage.

Parameters:
DEPTH, 4, FIFO entries; power of two, 2..16
ADDR_W, 8, instruction word-address width; matches PC_reg width
DATA_W, 32, instruction width
RESET_PC, 0, fetch address after reset

Ports:
clk  in  1  clock; all state updates on rising edge
reset  in  1  synchronous, active-high reset
hold  in  1  decode stall; head not consumed while high
redirect  in  1  branch/jump taken; flush and refetch
redirect_pc  in  ADDR_W  new fetch address, sampled when redirect=1
imem_req  out  1  fetch request
imem_addr  out  ADDR_W  requested word address
imem_gnt  in  1  memory accepted request this cycle
imem_rvalid  in  1  response valid; at least 1 cycle after gnt, in order
imem_rdata  in  DATA_W  response instruction
out_valid  out  1  head entry valid
out_instr  out  DATA_W  head instruction, to IF/ID iIR
out_pc_p1  out  ADDR_W  head address + 1, to IF/ID iPC
fifo_count  out  clog2(DEPTH)+1  current occupancy

Behaviour:
- Reset (reset=1 at a clock edge):
  - fetch_pc=RESET_PC, count=0, rd/wr pointers=0, state=FETCH.
  - All outputs 0 while reset is high.
  - Reset overrides every other input, including mid-transaction; the bench must not return rvalid for a pre-reset request.
- At most one outstanding memory request.
- State FETCH:
  - imem_req = (count < DEPTH) and not redirect.
  - imem_addr = fetch_pc.
  - req, once raised, holds with addr stable until gnt unless redirect.
  - On req&&gnt: save req_pc=fetch_pc, fetch_pc=fetch_pc+1 (wraps mod 2^ADDR_W, 255→0 at default width), go to WAIT.
- State WAIT:
  - imem_req=0.
  - On rvalid: push {imem_rdata, req_pc+1} (wraps), go to FETCH.
- State DROP:
  - imem_req=0.
  - On rvalid: discard the data, go to FETCH.
- Redirect (highest priority after reset), same edge:
  - count=0, pointers=0, fetch_pc=redirect_pc; out_valid=0 from the next cycle.
  - FETCH with req&&gnt in the same cycle: req is forced to 0, so no grant occurs; stay FETCH.
  - WAIT without rvalid: go to DROP.
  - WAIT with rvalid: data discarded, go to FETCH.
  - DROP: stay DROP; fetch_pc updated.
- Output side:
  - out_valid = (count != 0).
  - out_instr and out_pc_p1 come straight from the FIFO head (registered storage, no combinational path from imem_rdata).
  - pop = out_valid && !hold && !redirect.
  - Simultaneous push and pop: count unchanged, both pointers advance.
- Full:
  - The issue gate count<DEPTH plus the single outstanding request guarantee a push never overflows.
  - With count=DEPTH-1, one request may issue; count reaches DEPTH and req stays low until a pop.
- Latency: req&&gnt at cycle N, rvalid at N+1 → out_valid at N+2 (if the FIFO was empty). The next request issues at N+2.
- hold has no effect on fetching; fetching continues until full.

Optional Feature:
FETCH_PERF_EN.
- Defined: adds outputs perf_stall_cycles[31:0] and perf_drops[15:0].
  - perf_stall_cycles counts cycles with state=FETCH and count=DEPTH.
  - perf_drops counts responses discarded by redirect (DROP completions plus WAIT+rvalid+redirect).
  - Both saturate at their maximum; both reset to 0.
- Undefined: ports and logic are absent; behaviour is otherwise identical.

Test Plan:
- Reset then 1-cycle memory, hold=0:
  - imem_addr sequence is 0,1,2,…
  - out_valid first high 2 cycles after the first gnt, with out_instr=mem[0] and out_pc_p1=1.
  - Thereafter one instruction every 2 cycles, in order.
- hold=1 for 20 cycles with 1-cycle memory:
  - fifo_count climbs to 4 and imem_req stays 0.
  - Head stays mem[0]; after hold falls, mem[0..3] are delivered then fetching resumes at addr 4.
- Redirect to 0x40 while in WAIT, with rvalid arriving 3 cycles later:
  - That response is dropped and the FIFO is empty the next cycle.
  - Next imem_addr=0x40; first output is out_pc_p1=0x41.
- Redirect in the same cycle as rvalid:
  - Data is not enqueued; req reasserts with addr=redirect_pc the next cycle (no DROP).
- Wrap-around: redirect to 0xFE:
  - Outputs out_pc_p1=0xFF, 0x00, 0x01; imem_addr goes 0xFE, 0xFF, 0x00.
- Reset asserted while in WAIT with count=2:
  - Next cycle all outputs are 0, count=0, and imem_addr=RESET_PC is requested on the cycle after reset deasserts.
  - With FETCH_PERF_EN defined, both counters read 0.
